// File: rtl/lc3b_write_buffer_if.sv
// rtl/lc3b_write_buffer_if.sv - eviction, lookup, memory-write and status bundle for the write buffer
// Ports carried:
//   evict_valid/evict_ready/evict_addr/evict_data : dirty-line hand-off from the cache
//   lookup_addr/lookup_hit/lookup_data            : miss snoop into buffered lines
//   mem_write/mem_address/mem_wdata/mem_resp      : write channel to the next memory level
//   count/full/empty                              : occupancy status
// master = cache/memory side, slave = write buffer.
interface lc3b_write_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 128,
  parameter int ADDR_W = 12
);
  logic                       evict_valid;
  logic                       evict_ready;
  logic [ADDR_W-1:0]          evict_addr;
  logic [LINE_W-1:0]          evict_data;
  logic [ADDR_W-1:0]          lookup_addr;
  logic                       lookup_hit;
  logic [LINE_W-1:0]          lookup_data;
  logic                       mem_write;
  logic [ADDR_W-1:0]          mem_address;
  logic [LINE_W-1:0]          mem_wdata;
  logic                       mem_resp;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       full;
  logic                       empty;

  modport master (
    output evict_valid, evict_addr, evict_data, lookup_addr, mem_resp,
    input  evict_ready, lookup_hit, lookup_data, mem_write, mem_address, mem_wdata,
           count, full, empty
  );

  modport slave (
    input  evict_valid, evict_addr, evict_data, lookup_addr, mem_resp,
    output evict_ready, lookup_hit, lookup_data, mem_write, mem_address, mem_wdata,
           count, full, empty
  );
endinterface

// File: rtl/lc3b_write_buffer.sv
// rtl/lc3b_write_buffer.sv - coalescing circular write buffer for dirty L1 line evictions
// Ports:
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : lc3b_write_buffer_if.slave (evict/lookup/memory/status signals)
// Evicted lines are queued in arrival order and drained one at a time to memory.
// An eviction to an address already buffered overwrites that entry in place,
// except the head while it is being written out, which must stay stable.
module lc3b_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 128,
  parameter int ADDR_W = 12
) (
  input logic                clk,
  input logic                reset_n,
  lc3b_write_buffer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [LINE_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic [PW-1:0]     w_idx;
  logic              w_co_hit;
  logic [PW-1:0]     w_co_idx;
  logic              w_lk_hit;
  logic [LINE_W-1:0] w_lk_data;
  logic              w_full;
  logic              w_empty;
  logic              w_ready;
  logic              w_handshake;
  logic              w_alloc;
  logic              w_retire;
  logic              w_mem_write;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Walk entries oldest to youngest so the last match seen is the youngest.
  // The head is excluded from coalescing while its write is in flight.
  always_comb begin
    w_idx     = '0;
    w_co_hit  = 1'b0;
    w_co_idx  = '0;
    w_lk_hit  = 1'b0;
    w_lk_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = PW'((int'(r_head) + k) % DEPTH);
      if (r_valid[w_idx] && (r_addr[w_idx] == bus.evict_addr) &&
          !((r_state == S_DRAIN) && (w_idx == r_head))) begin
        w_co_hit = 1'b1;
        w_co_idx = w_idx;
      end
      if (r_valid[w_idx] && (r_addr[w_idx] == bus.lookup_addr)) begin
        w_lk_hit  = 1'b1;
        w_lk_data = r_data[w_idx];
      end
    end
  end

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_ready     = !w_full || w_co_hit;
  assign w_handshake = bus.evict_valid && w_ready;
  assign w_alloc     = w_handshake && !w_co_hit;

  always_comb begin
    w_state_nxt = r_state;
    w_mem_write = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_mem_write = 1'b1;
        if (bus.mem_resp) begin
          w_retire    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Allocation and retirement never touch the same slot: DRAIN implies
      // count > 0 and allocation implies not full, so tail != head.
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= f_inc(r_tail);
      end
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= f_inc(r_head);
      end
      r_count <= r_count + CW'(w_alloc) - CW'(w_retire);
    end
  end

  // Payload storage is unreset; every consumer qualifies it with r_valid.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addr[r_tail] <= bus.evict_addr;
      r_data[r_tail] <= bus.evict_data;
    end else if (w_handshake) begin
      r_data[w_co_idx] <= bus.evict_data;
    end
  end

  assign bus.evict_ready = w_ready;
  assign bus.lookup_hit  = w_lk_hit;
  assign bus.lookup_data = w_lk_data;
  assign bus.mem_write   = w_mem_write;
  assign bus.mem_address = (w_mem_write && r_valid[r_head]) ? r_addr[r_head] : '0;
  assign bus.mem_wdata   = (w_mem_write && r_valid[r_head]) ? r_data[r_head] : '0;
  assign bus.count       = r_count;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
endmodule

// File: tb/tb_lc3b_write_buffer.sv
// tb/tb_lc3b_write_buffer.sv - directed scoreboard bench for lc3b_write_buffer
module tb_lc3b_write_buffer;
  localparam int DEPTH  = 4;
  localparam int LINE_W = 128;
  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lc3b_write_buffer_if #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

  lc3b_write_buffer #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } ent_t;

  ent_t sb_q[$];
  bit   m_drain = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   writes = 0;

  function automatic logic [LINE_W-1:0] pat(input int n);
    logic [31:0] w;
    w = 32'(n) ^ 32'hA5C3_0000;
    return {w, ~w, w + 32'd7, w ^ 32'h0F0F_0F0F};
  endfunction

  function automatic int co_idx(input logic [ADDR_W-1:0] a);
    for (int j = sb_q.size() - 1; j >= (m_drain ? 1 : 0); j--)
      if (sb_q[j].addr == a) return j;
    return -1;
  endfunction

  function automatic int lk_idx(input logic [ADDR_W-1:0] a);
    for (int j = sb_q.size() - 1; j >= 0; j--)
      if (sb_q[j].addr == a) return j;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive on the falling edge, compare the DUT against
  // the scoreboard, then retire/append scoreboard entries as the cycle commits.
  task automatic step(input bit ev, input logic [ADDR_W-1:0] a,
                      input logic [LINE_W-1:0] d, input bit resp);
    int j;
    int n_before;
    bit exp_ready;
    @(negedge clk);
    bus.evict_valid = ev;
    bus.evict_addr  = a;
    bus.evict_data  = d;
    bus.mem_resp    = resp;
    #1;
    j         = co_idx(a);
    n_before  = sb_q.size();
    exp_ready = (n_before < DEPTH) || (j >= 0);
    chk("evict_ready", bus.evict_ready, exp_ready);
    chk("count", bus.count, n_before);
    chk("full", bus.full, n_before == DEPTH);
    chk("empty", bus.empty, n_before == 0);
    chk("mem_write", bus.mem_write, m_drain);
    if (m_drain) begin
      chk("mem_address", bus.mem_address, sb_q[0].addr);
      chk("mem_wdata", bus.mem_wdata, sb_q[0].data);
    end
    if (ev && exp_ready) begin
      if (j >= 0) sb_q[j].data = d;
      else sb_q.push_back(ent_t'{a, d});
    end
    if (m_drain && resp) begin
      void'(sb_q.pop_front());
      writes++;
      m_drain = 1'b0;
    end else if (!m_drain && n_before > 0) begin
      m_drain = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic check_lookup(input logic [ADDR_W-1:0] a);
    int j;
    bus.lookup_addr = a;
    #1;
    j = lk_idx(a);
    chk("lookup_hit", bus.lookup_hit, j >= 0);
    chk("lookup_data", bus.lookup_data, (j >= 0) ? sb_q[j].data : '0);
  endtask

  task automatic drain_all();
    for (int n = 0; n < 60; n++) begin
      if (sb_q.size() == 0) break;
      step(1'b0, '0, '0, 1'b1);
    end
    chk("drain_bound", sb_q.size(), 0);
    #1;
    chk("drain_empty", bus.empty, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.evict_valid = 1'b0;
    bus.evict_addr  = '0;
    bus.evict_data  = '0;
    bus.lookup_addr = '0;
    bus.mem_resp    = 1'b0;

    // Reset state
    #12;
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_evict_ready", bus.evict_ready, 1'b1);
    chk("rst_lookup_hit", bus.lookup_hit, 1'b0);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_count", bus.count, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Fill to DEPTH with no completions
    for (int i = 0; i < 4; i++) step(1'b1, ADDR_W'(12'h010 + i), pat(i), 1'b0);
    step(1'b1, 12'h020, pat(20), 1'b0);
    #1;
    chk("fill_count", bus.count, 4);
    chk("fill_full", bus.full, 1'b1);
    chk("fill_ready_new", bus.evict_ready, 1'b0);
    chk("fill_head_addr", bus.mem_address, 12'h010);

    // Coalesce into a non-head entry while full
    check_lookup(12'h011);
    step(1'b1, 12'h011, pat(100), 1'b0);
    #1;
    chk("coal_count", bus.count, 4);
    check_lookup(12'h011);
    chk("coal_data", bus.lookup_data, pat(100));
    drain_all();

    // Same address as the in-flight head must allocate, not overwrite
    step(1'b1, 12'h010, pat(200), 1'b0);
    step(1'b0, '0, '0, 1'b0);
    step(1'b1, 12'h010, pat(201), 1'b0);
    #1;
    chk("inflight_count", bus.count, 2);
    chk("inflight_wdata", bus.mem_wdata, pat(200));
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);

    // Allocation and completion in the same cycle
    step(1'b1, 12'h030, pat(202), 1'b1);
    #1;
    chk("simul_count", bus.count, 2);
    check_lookup(12'h030);
    drain_all();

    // Pointer wrap with interleaved completions
    writes = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, ADDR_W'(12'h100 + i), pat(300 + i), 1'b1);
      step(1'b0, '0, '0, 1'b1);
    end
    drain_all();
    chk("wrap_writes", writes, 9);

    // Reset in the middle of a drain
    step(1'b1, 12'h200, pat(400), 1'b0);
    step(1'b1, 12'h201, pat(401), 1'b0);
    step(1'b1, 12'h202, pat(402), 1'b0);
    step(1'b0, '0, '0, 1'b0);
    #1;
    chk("pre_rst_count", bus.count, 3);
    chk("pre_rst_mem_write", bus.mem_write, 1'b1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    sb_q.delete();
    m_drain = 1'b0;
    chk("midrst_mem_write", bus.mem_write, 1'b0);
    chk("midrst_count", bus.count, 0);
    chk("midrst_empty", bus.empty, 1'b1);
    for (int i = 0; i < 3; i++) check_lookup(ADDR_W'(12'h200 + i));
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lc3b_write_buffer.md
LC3B_WRITE_BUFFER -- requirements
Module: lc3b_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered dirty lines; legal range 2..16.
REQ-002 Parameter LINE_W, default 128, line width in bits; matches lc3b_l1_line.
REQ-003 Parameter ADDR_W, default 12, line address width (tag concatenated with index).
REQ-004 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1, reset, asynchronous and active-low.
REQ-006 Port evict_valid, input, 1, upstream cache presents a dirty line.
REQ-007 Port evict_ready, output, 1, buffer accepts the line this cycle.
REQ-008 Port evict_addr, input, ADDR_W, line address of the evicted line.
REQ-009 Port evict_data, input, LINE_W, evicted line data.
REQ-010 Port lookup_addr, input, ADDR_W, line address of an upstream miss.
REQ-011 Port lookup_hit, output, 1, a buffered entry matches lookup_addr.
REQ-012 Port lookup_data, output, LINE_W, data of the matching entry.
REQ-013 Port mem_write, output, 1, write request to the next memory level.
REQ-014 Port mem_address, output, ADDR_W, line address of the write.
REQ-015 Port mem_wdata, output, LINE_W, line data of the write.
REQ-016 Port mem_resp, input, 1, single-cycle completion pulse from memory.
REQ-017 Port count, output, $clog2(DEPTH+1), number of valid entries.
REQ-018 Port full, output, 1, count equals DEPTH; Port empty, output, 1, count equals 0.

Function
REQ-019 Storage SHALL be a circular FIFO of DEPTH entries, each holding valid, addr and data, with head and tail pointers wrapping from DEPTH-1 to 0.
REQ-020 A handshake SHALL occur in a cycle where evict_valid and evict_ready are both 1.
REQ-021 evict_ready SHALL be 1 when the buffer is not full, or when evict_addr matches a coalescible entry.
REQ-022 Coalescing: on a handshake whose evict_addr matches a valid entry that is not the head in DRAIN, that entry's data SHALL be overwritten in place; count and tail SHALL be unchanged.
REQ-023 On a handshake with no coalescible match, the line SHALL be written at tail, tail SHALL advance, and count SHALL increment.
REQ-024 An eviction matching only the head while it is in DRAIN SHALL allocate a new entry and SHALL NOT modify the in-flight data.
REQ-025 lookup_hit and lookup_data SHALL be combinational from lookup_addr and current state; on multiple matches the youngest entry (closest to tail) wins; lookup_data SHALL be 0 on a miss.
REQ-026 The drain FSM SHALL have two states. IDLE moves to DRAIN when the buffer is not empty. DRAIN moves to IDLE on mem_resp.
REQ-027 In DRAIN, mem_write SHALL be 1 and mem_address and mem_wdata SHALL present the head entry, held stable until mem_resp.
REQ-028 On mem_resp, the head SHALL be invalidated, head SHALL advance, count SHALL decrement, and the FSM SHALL return to IDLE; the next write SHALL begin no earlier than the following cycle.
REQ-029 If a handshake and mem_resp occur in the same cycle, count SHALL be net unchanged for an allocation, or net -1 for a coalesce.
REQ-030 mem_resp while in IDLE SHALL be ignored.
REQ-031 full and empty SHALL be derived from count only.

Reset
REQ-032 While reset_n is 0, regardless of clk: all valid bits, head, tail and count SHALL be 0, and the FSM SHALL be in IDLE.
REQ-033 Reset outputs: mem_write=0, evict_ready=1, lookup_hit=0, empty=1, full=0.
REQ-034 Assertion of reset mid-DRAIN SHALL drop mem_write immediately and discard all buffered lines; no completion is owed to memory.
REQ-035 Entry data registers need no reset; outputs derived from them SHALL be masked by valid.

Verification
REQ-036 Fill: 4 evictions to addrs 0x010..0x013 with mem_resp held 0 -> count=4, full=1, evict_ready=0 for new addr 0x020, mem_address=0x010.
REQ-037 Coalesce: buffer holds 0x011 (data A) not at head; evict 0x011 with data B -> count unchanged, lookup_addr=0x011 gives lookup_hit=1, lookup_data=B.
REQ-038 In-flight: head 0x010 in DRAIN with data A; evict 0x010 with data B -> count+1, mem_wdata stays A until mem_resp, then the next write sends 0x010/B.
REQ-039 Simultaneous: count=2, handshake to new addr and mem_resp in the same cycle -> count=2 next cycle, head and tail both advanced by 1.
REQ-040 Wrap: 9 allocations interleaved with mem_resp at DEPTH=4 -> lines written to memory in exact arrival order; empty=1 at the end.
REQ-041 Reset: reset_n pulled to 0 mid-DRAIN with count=3 -> mem_write=0 in the same cycle, count=0, lookup_hit=0 for all earlier addresses.
